// File: rtl/image_arb_pkg.sv
// Shared types and default widths for the image memory arbiter.
package image_arb_pkg;

    localparam int IMG_ADDR_W = 18;
    localparam int IMG_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        VGA_OWN    = 2'd1,
        CPU_OWN    = 2'd2,
        CPU_FORCED = 2'd3
    } arb_state_t;

endpackage

// File: rtl/image_mem_arbiter_wait_counter.sv
// Saturating count of consecutive cycles the CPU has been denied the image memory.
module arb_wait_counter #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CW = (MAX < 1) ? 1 : $clog2(MAX + 1);
    localparam logic [CW-1:0] MAX_V = CW'(MAX);

    logic [CW-1:0] cnt_r;

    // Clear wins over increment; hold once the limit is reached.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (inc && (cnt_r != MAX_V)) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign sat = (cnt_r == MAX_V);

endmodule

// File: rtl/image_mem_arbiter.sv
// Shares the single-port image memory between the CPU data port and the VGA fetcher;
// VGA wins by default, a starvation counter bounds how long the CPU can be held off.
module image_mem_arbiter
    import image_arb_pkg::*;
#(
    parameter int ADDR_W   = IMG_ADDR_W,
    parameter int DATA_W   = IMG_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_adr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_adr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_miss,
    output logic [ADDR_W-1:0] mem_adr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t state_r;
    arb_state_t state_nxt_s;
    logic       cpu_gnt_s;
    logic       vga_gnt_s;
    logic       wait_sat_s;
    logic       cpu_rvalid_r;
    logic       vga_rvalid_r;

    arb_wait_counter #(
        .MAX (MAX_WAIT)
    ) u_wait_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (cpu_req & ~cpu_gnt_s),
        .clr   (cpu_gnt_s | ~cpu_req),
        .sat   (wait_sat_s)
    );

    // Priority arbitration; a forced CPU grant always yields the next slot to VGA.
    always_comb begin
        cpu_gnt_s   = 1'b0;
        vga_gnt_s   = 1'b0;
        state_nxt_s = IDLE;
        if (reset) begin
            state_nxt_s = IDLE;
        end else if ((state_r == CPU_FORCED) && vga_req) begin
            vga_gnt_s   = 1'b1;
            state_nxt_s = VGA_OWN;
        end else if (cpu_req && wait_sat_s) begin
            cpu_gnt_s   = 1'b1;
            state_nxt_s = CPU_FORCED;
        end else if (vga_req) begin
            vga_gnt_s   = 1'b1;
            state_nxt_s = VGA_OWN;
        end else if (cpu_req) begin
            cpu_gnt_s   = 1'b1;
            state_nxt_s = CPU_OWN;
        end else begin
            state_nxt_s = IDLE;
        end
    end

    // Winner register and read-return pipeline matching the memory's one-cycle latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            cpu_rvalid_r <= 1'b0;
            vga_rvalid_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cpu_rvalid_r <= cpu_gnt_s & ~cpu_we;
            vga_rvalid_r <= vga_gnt_s;
        end
    end

    assign cpu_gnt    = cpu_gnt_s;
    assign vga_gnt    = vga_gnt_s;
    assign cpu_stall  = cpu_req & ~cpu_gnt_s;
    assign vga_miss   = vga_req & ~vga_gnt_s & ~reset;
    assign mem_adr    = vga_gnt_s ? vga_adr : cpu_adr;
    assign mem_we     = cpu_gnt_s & cpu_we;
    assign mem_wdata  = cpu_wdata;
    assign cpu_rvalid = cpu_rvalid_r;
    assign vga_rvalid = vga_rvalid_r;
    assign cpu_rdata  = cpu_rvalid_r ? mem_rdata : {DATA_W{1'b0}};
    assign vga_rdata  = vga_rvalid_r ? mem_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_image_mem_arbiter.sv
// Directed bench for image_mem_arbiter with a registered-read memory model (MAX_WAIT=4).
module tb_image_mem_arbiter;
    import image_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [17:0] cpu_adr;
    logic [7:0]  cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_stall;
    logic        cpu_rvalid;
    logic [7:0]  cpu_rdata;
    logic        vga_req;
    logic [17:0] vga_adr;
    logic        vga_gnt;
    logic        vga_rvalid;
    logic [7:0]  vga_rdata;
    logic        vga_miss;
    logic [17:0] mem_adr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem [0:262143];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    image_mem_arbiter #(
        .ADDR_W   (18),
        .DATA_W   (8),
        .MAX_WAIT (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_adr    (cpu_adr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .vga_req    (vga_req),
        .vga_adr    (vga_adr),
        .vga_gnt    (vga_gnt),
        .vga_rvalid (vga_rvalid),
        .vga_rdata  (vga_rdata),
        .vga_miss   (vga_miss),
        .mem_adr    (mem_adr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Single-port memory with registered read data.
    always @(posedge clk) begin
        if (mem_we) mem[mem_adr] <= mem_wdata;
        mem_rdata <= mem[mem_adr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_cpu;
        logic prev_vga;

        mem[18'h00200] = 8'h3C;
        mem[18'h00010] = 8'h00;

        // 1: reset held with both requests pending
        reset = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 18'h00010; cpu_wdata = 8'h77;
        vga_req = 1'b1; vga_adr = 18'h00200;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
            chk("rst_vga_gnt", 32'(vga_gnt), 32'd0);
            chk("rst_mem_we", 32'(mem_we), 32'd0);
            chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
            chk("rst_vga_rvalid", 32'(vga_rvalid), 32'd0);
            chk("rst_vga_miss", 32'(vga_miss), 32'd0);
            tick();
        end
        reset = 1'b0; cpu_req = 1'b0; vga_req = 1'b0;
        @(negedge clk);
        chk("idle_state", 32'(dut.state_r), 32'(IDLE));
        chk("idle_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("idle_vga_gnt", 32'(vga_gnt), 32'd0);
        tick();

        // 2: CPU-only write then read back
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 18'h00010; cpu_wdata = 8'hA5;
        @(negedge clk);
        chk("wr_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("wr_mem_we", 32'(mem_we), 32'd1);
        chk("wr_mem_adr", 32'(mem_adr), 32'h00010);
        chk("wr_mem_wdata", 32'(mem_wdata), 32'hA5);
        chk("wr_cpu_stall", 32'(cpu_stall), 32'd0);
        tick();
        cpu_we = 1'b0;
        @(negedge clk);
        chk("rd_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("rd_mem_we", 32'(mem_we), 32'd0);
        chk("wr_no_rvalid", 32'(cpu_rvalid), 32'd0);
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        chk("rd_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("rd_cpu_rdata", 32'(cpu_rdata), 32'hA5);
        chk("rd_vga_rvalid", 32'(vga_rvalid), 32'd0);
        tick();
        @(negedge clk);
        chk("rd_cpu_rvalid_off", 32'(cpu_rvalid), 32'd0);
        chk("rd_cpu_rdata_zero", 32'(cpu_rdata), 32'h00);
        tick();

        // 3+4: both requesting; CPU forced every 5th cycle, VGA always follows a forced grant
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 18'h00010;
        vga_req = 1'b1; vga_adr = 18'h00200;
        for (int i = 0; i < 12; i++) begin
            exp_cpu  = (i == 4) || (i == 9);
            prev_vga = (i > 0) && !((i - 1 == 4) || (i - 1 == 9));
            @(negedge clk);
            chk($sformatf("pat_cpu_gnt[%0d]", i), 32'(cpu_gnt), 32'(exp_cpu));
            chk($sformatf("pat_vga_gnt[%0d]", i), 32'(vga_gnt), 32'(!exp_cpu));
            chk($sformatf("pat_cpu_stall[%0d]", i), 32'(cpu_stall), 32'(!exp_cpu));
            chk($sformatf("pat_vga_miss[%0d]", i), 32'(vga_miss), 32'(exp_cpu));
            chk($sformatf("pat_mem_adr[%0d]", i), 32'(mem_adr), exp_cpu ? 32'h00010 : 32'h00200);
            chk($sformatf("pat_vga_rvalid[%0d]", i), 32'(vga_rvalid), 32'(prev_vga));
            chk($sformatf("pat_vga_rdata[%0d]", i), 32'(vga_rdata), prev_vga ? 32'h3C : 32'h00);
            chk($sformatf("pat_cpu_rdata[%0d]", i), 32'(cpu_rdata),
                ((i == 5) || (i == 10)) ? 32'hA5 : 32'h00);
            if (i == 5) chk("forced_state", 32'(dut.state_r), 32'(CPU_FORCED));
            tick();
        end

        // 5: CPU drops its request after two denials, then waits the full four again
        cpu_req = 1'b0; vga_req = 1'b0;
        tick();
        cpu_req = 1'b1; vga_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("drop_pre_cpu_gnt[%0d]", i), 32'(cpu_gnt), 32'd0);
            tick();
        end
        cpu_req = 1'b0;
        @(negedge clk);
        chk("drop_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("drop_cpu_stall", 32'(cpu_stall), 32'd0);
        tick();
        cpu_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) chk("drop_no_rvalid", 32'(cpu_rvalid), 32'd0);
            chk($sformatf("rearm_cpu_gnt[%0d]", i), 32'(cpu_gnt), 32'(i == 4));
            chk($sformatf("rearm_vga_gnt[%0d]", i), 32'(vga_gnt), 32'(i != 4));
            tick();
        end

        // 6: reset lands the cycle after a VGA read grant
        cpu_req = 1'b0; vga_req = 1'b1; vga_adr = 18'h00200;
        @(negedge clk);
        chk("r6_vga_gnt", 32'(vga_gnt), 32'd1);
        tick();
        reset = 1'b1; vga_req = 1'b0;
        @(negedge clk);
        chk("r6_rst_vga_gnt", 32'(vga_gnt), 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("r6_vga_rvalid", 32'(vga_rvalid), 32'd0);
        chk("r6_vga_rdata", 32'(vga_rdata), 32'h00);
        chk("r6_state", 32'(dut.state_r), 32'(IDLE));
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
